// File: rtl/float_pack_if.sv
// Request/response and byte-write bundle between a requester and the float_pack coprocessor.
// The requester drives the operands and Start; the coprocessor returns status, the packed word and memory writes.
interface float_pack_if #(
   parameter int ADDR_W = 8
);
   logic              Start;
   logic              Sign;
   logic [5:0]        Exp;
   logic [15:0]       Mant;
   logic              Busy;
   logic              Done;
   logic [15:0]       Result;
   logic              MemWrEn;
   logic [ADDR_W-1:0] MemAddr;
   logic [7:0]        MemData;

   modport master (
      output Start, Sign, Exp, Mant,
      input  Busy, Done, Result, MemWrEn, MemAddr, MemData
   );

   modport slave (
      input  Start, Sign, Exp, Mant,
      output Busy, Done, Result, MemWrEn, MemAddr, MemData
   );
endinterface

// File: rtl/float_pack.sv
// Serial half-precision packer: normalises one shift per cycle, rounds, then stores the word as two bytes.
// Define FLOAT_PACK_SUBNORM_EN to produce subnormal results instead of flushing small values to signed zero.
module float_pack #(
   parameter int ADDR_W    = 8,
   parameter int BASE_ADDR = 4
) (
   input logic         Clk,
   input logic         Reset,
   float_pack_if.slave bus
);
   localparam logic [ADDR_W-1:0] ADDR_LO = ADDR_W'(BASE_ADDR);
   localparam logic [ADDR_W-1:0] ADDR_HI = ADDR_W'(BASE_ADDR + 1);

   typedef enum logic [3:0] {
      S_IDLE,
      S_LOAD,
      S_NORM,
`ifdef FLOAT_PACK_SUBNORM_EN
      S_DENORM,
`endif
      S_ROUND,
      S_PACK,
      S_WR_LO,
      S_WR_HI,
      S_DONE
   } state_t;

   state_t             state_q, state_d;
   logic               sign_q, sign_d;
   logic signed [7:0]  exp_q, exp_d;
   logic [15:0]        mant_q, mant_d;
   logic               guard_q, guard_d;
   logic               sticky_q, sticky_d;
`ifdef FLOAT_PACK_SUBNORM_EN
   logic [3:0]         denCnt_q, denCnt_d;
`endif

   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic [15:0]        result_q, result_d;
   logic               memWrEn_q, memWrEn_d;
   logic [ADDR_W-1:0]  memAddr_q, memAddr_d;
   logic [7:0]         memData_q, memData_d;

   logic [3:0]         msbIdx;
   logic               roundInc;
   logic [11:0]        roundSum;
   logic signed [7:0]  biasExp;

   assign bus.Busy    = busy_q;
   assign bus.Done    = done_q;
   assign bus.Result  = result_q;
   assign bus.MemWrEn = memWrEn_q;
   assign bus.MemAddr = memAddr_q;
   assign bus.MemData = memData_q;

   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_q   <= S_IDLE;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         result_q  <= '0;
         memWrEn_q <= 1'b0;
         memAddr_q <= '0;
         memData_q <= '0;
      end else begin
         state_q   <= state_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         result_q  <= result_d;
         memWrEn_q <= memWrEn_d;
         memAddr_q <= memAddr_d;
         memData_q <= memData_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sign_q   <= 1'b0;
         exp_q    <= '0;
         mant_q   <= '0;
         guard_q  <= 1'b0;
         sticky_q <= 1'b0;
`ifdef FLOAT_PACK_SUBNORM_EN
         denCnt_q <= '0;
`endif
      end else begin
         sign_q   <= sign_d;
         exp_q    <= exp_d;
         mant_q   <= mant_d;
         guard_q  <= guard_d;
         sticky_q <= sticky_d;
`ifdef FLOAT_PACK_SUBNORM_EN
         denCnt_q <= denCnt_d;
`endif
      end
   end

   always_comb begin
      msbIdx = '0;
      for (int i = 0; i < 16; i++) begin
         if (mant_q[i]) msbIdx = 4'(i);
      end
   end

   // Right shifts retire the old guard into sticky, so rounding sees every discarded bit exactly once.
   always_comb begin
      sign_d   = sign_q;
      exp_d    = exp_q;
      mant_d   = mant_q;
      guard_d  = guard_q;
      sticky_d = sticky_q;
`ifdef FLOAT_PACK_SUBNORM_EN
      denCnt_d = denCnt_q;
`endif
      roundInc = guard_q & (sticky_q | mant_q[0]);
      roundSum = {1'b0, mant_q[10:0]} + {11'b0, roundInc};
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               sign_d   = bus.Sign;
               exp_d    = {{2{bus.Exp[5]}}, bus.Exp};
               mant_d   = bus.Mant;
               guard_d  = 1'b0;
               sticky_d = 1'b0;
            end
         end
         S_NORM: begin
            if (msbIdx > 4'd10) begin
               mant_d   = mant_q >> 1;
               exp_d    = exp_q + 8'sd1;
               guard_d  = mant_q[0];
               sticky_d = sticky_q | guard_q;
            end else if (msbIdx < 4'd10) begin
               mant_d = mant_q << 1;
               exp_d  = exp_q - 8'sd1;
            end
`ifdef FLOAT_PACK_SUBNORM_EN
            denCnt_d = '0;
`endif
         end
`ifdef FLOAT_PACK_SUBNORM_EN
         S_DENORM: begin
            mant_d   = mant_q >> 1;
            exp_d    = exp_q + 8'sd1;
            guard_d  = mant_q[0];
            sticky_d = sticky_q | guard_q;
            denCnt_d = denCnt_q + 4'd1;
         end
`endif
         S_ROUND: begin
            if (roundSum[11]) begin
               mant_d = 16'h0400;
               exp_d  = exp_q + 8'sd1;
            end else begin
               mant_d = {5'b0, roundSum[10:0]};
            end
         end
         default: ;
      endcase
   end

   // NORM exits once the shift made this cycle lands the leading one on bit 10.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.Start) state_d = S_LOAD;
         S_LOAD:  state_d = (mant_q == '0) ? S_PACK : S_NORM;
         S_NORM: begin
            if (msbIdx >= 4'd9 && msbIdx <= 4'd11) begin
`ifdef FLOAT_PACK_SUBNORM_EN
               state_d = (exp_d <= -8'sd15) ? S_DENORM : S_ROUND;
`else
               state_d = S_ROUND;
`endif
            end
         end
`ifdef FLOAT_PACK_SUBNORM_EN
         S_DENORM: if (exp_q == -8'sd15 || denCnt_q == 4'd11) state_d = S_ROUND;
`endif
         S_ROUND: state_d = S_PACK;
         S_PACK:  state_d = S_WR_LO;
         S_WR_LO: state_d = S_WR_HI;
         S_WR_HI: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Outputs are decoded from the next state so every port comes straight from a flop.
   always_comb begin
      result_d = result_q;
      biasExp  = exp_q + 8'sd15;
      if (state_q == S_PACK) begin
         if (mant_q == '0) begin
            result_d = {sign_q, 15'b0};
         end else if (biasExp >= 8'sd31) begin
            result_d = {sign_q, 15'h7BFF};
`ifdef FLOAT_PACK_SUBNORM_EN
         end else begin
            result_d = {sign_q, (mant_q[10] ? biasExp[4:0] : 5'd0), mant_q[9:0]};
         end
`else
         end else if (biasExp <= 8'sd0) begin
            result_d = {sign_q, 15'b0};
         end else begin
            result_d = {sign_q, biasExp[4:0], mant_q[9:0]};
         end
`endif
      end
      busy_d    = (state_d != S_IDLE);
      done_d    = (state_d == S_DONE);
      memWrEn_d = (state_d == S_WR_LO) || (state_d == S_WR_HI);
      memAddr_d = '0;
      memData_d = '0;
      if (state_d == S_WR_LO) begin
         memAddr_d = ADDR_LO;
         memData_d = result_d[7:0];
      end else if (state_d == S_WR_HI) begin
         memAddr_d = ADDR_HI;
         memData_d = result_d[15:8];
      end
   end
endmodule

// File: tb/tb_float_pack.sv
// Self-checking bench for float_pack: directed table, randomised vectors against an arithmetic model,
// and hand sequences for reset during a write and Start while busy.
module tb_float_pack;
   localparam int ADDR_W      = 8;
   localparam int BASE_ADDR   = 4;
   localparam int DONE_BUDGET = 80;

   logic clk;
   logic reset;
   int   checks;
   int   errors;

   float_pack_if #(.ADDR_W(ADDR_W)) bus();

   float_pack #(.ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
      .Clk   (clk),
      .Reset (reset),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   typedef struct {
      logic        sign;
      logic [5:0]  exp;
      logic [15:0] mant;
      logic [15:0] result;
      int          cycle;
   } vec_t;

   vec_t        vecs[$];
   logic [15:0] obsResult;
   int          obsDoneCycle;
   int          obsDoneCount;
   logic        obsBusyLoad;
   logic [7:0]  wrAddr[$];
   logic [7:0]  wrData[$];

   // Round-to-nearest-even of m / 2^sh (left shift when sh is not positive).
   function automatic longint roundShift(input longint m, input int sh);
      longint q, rem, half;
      if (sh <= 0) return m << (-sh);
      if (sh > 20) return 0;
      q    = m >> sh;
      rem  = m - (q << sh);
      half = longint'(1) << (sh - 1);
      if (rem > half || (rem == half && q[0])) q = q + 1;
      return q;
   endfunction

   function automatic logic [15:0] refModel(input logic s, input logic [5:0] e6, input logic [15:0] m);
      int     ev, p, e, bigE;
      longint q;
      if (m == 16'h0) return {s, 15'b0};
      ev = $signed(e6);
      p  = 15;
      while (m[p] == 1'b0) p--;
      e = ev + p - 10;
`ifdef FLOAT_PACK_SUBNORM_EN
      if (e + 15 <= 0) begin
         q = roundShift(longint'(m), -(ev + 14));
         return {s, q[14:0]};
      end
`endif
      q = roundShift(longint'(m), p - 10);
      if (q == 2048) begin
         q = 1024;
         e = e + 1;
      end
      bigE = e + 15;
      if (bigE >= 31) return {s, 15'h7BFF};
      if (bigE <= 0) return {s, 15'b0};
      return {s, bigE[4:0], q[9:0]};
   endfunction

   function automatic int refCycles(input logic [5:0] e6, input logic [15:0] m);
      int ev, p, n, d, e0;
      if (m == 16'h0) return 5;
      ev = $signed(e6);
      p  = 15;
      while (m[p] == 1'b0) p--;
      n = (p > 10) ? p - 10 : 10 - p;
      if (n == 0) n = 1;
      d  = 0;
      e0 = ev + p - 10 + 15;
`ifdef FLOAT_PACK_SUBNORM_EN
      if (e0 <= 0) d = (1 - e0 > 12) ? 12 : 1 - e0;
`endif
      return 6 + n + d;
   endfunction

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Starts one operation, scrambles the inputs after acceptance, and records writes and Done.
   task automatic applyStimulus(input logic s, input logic [5:0] e, input logic [15:0] m, input int pulseCycle);
      wrAddr.delete();
      wrData.delete();
      obsDoneCycle = -1;
      obsDoneCount = 0;
      obsBusyLoad  = 1'b0;
      obsResult    = 16'hxxxx;
      @(negedge clk);
      bus.Sign  = s;
      bus.Exp   = e;
      bus.Mant  = m;
      bus.Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      bus.Sign  = 1'($urandom);
      bus.Exp   = 6'($urandom);
      bus.Mant  = 16'($urandom);
      for (int c = 1; c <= DONE_BUDGET; c++) begin
         @(negedge clk);
         bus.Start = (c == pulseCycle);
         if (c == 1) obsBusyLoad = bus.Busy;
         if (bus.MemWrEn) begin
            wrAddr.push_back(bus.MemAddr);
            wrData.push_back(bus.MemData);
         end
         if (bus.Done) begin
            obsDoneCount++;
            if (obsDoneCycle < 0) begin
               obsDoneCycle = c;
               obsResult    = bus.Result;
            end
         end
         if (obsDoneCycle >= 0 && c >= obsDoneCycle + 6) break;
      end
      bus.Start = 1'b0;
   endtask

   task automatic checkOp(input string name, input logic [15:0] expRes, input int expCycle);
      checkOutput({name, " result"}, 32'(obsResult), 32'(expRes));
      checkOutput({name, " done cycle"}, 32'(obsDoneCycle), 32'(expCycle));
      checkOutput({name, " done pulses"}, 32'(obsDoneCount), 32'd1);
      checkOutput({name, " busy in load"}, 32'(obsBusyLoad), 32'd1);
      checkOutput({name, " write count"}, 32'(wrAddr.size()), 32'd2);
      if (wrAddr.size() == 2) begin
         checkOutput({name, " lo addr"}, 32'(wrAddr[0]), 32'(BASE_ADDR));
         checkOutput({name, " lo data"}, 32'(wrData[0]), 32'(expRes[7:0]));
         checkOutput({name, " hi addr"}, 32'(wrAddr[1]), 32'(BASE_ADDR + 1));
         checkOutput({name, " hi data"}, 32'(wrData[1]), 32'(expRes[15:8]));
      end
   endtask

   task automatic checkIdleOutputs(input string name);
      checkOutput({name, " Busy"}, 32'(bus.Busy), 32'd0);
      checkOutput({name, " Done"}, 32'(bus.Done), 32'd0);
      checkOutput({name, " Result"}, 32'(bus.Result), 32'd0);
      checkOutput({name, " MemWrEn"}, 32'(bus.MemWrEn), 32'd0);
      checkOutput({name, " MemAddr"}, 32'(bus.MemAddr), 32'd0);
      checkOutput({name, " MemData"}, 32'(bus.MemData), 32'd0);
   endtask

   initial begin
      logic        rs;
      logic [5:0]  re;
      logic [15:0] rm;
      bit          reached;
      int          doneSeen;

      checks    = 0;
      errors    = 0;
      reset     = 1'b1;
      bus.Start = 1'b0;
      bus.Sign  = 1'b0;
      bus.Exp   = '0;
      bus.Mant  = '0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkIdleOutputs("reset");
      reset = 1'b0;

      vecs.push_back('{1'b0, 6'h00, 16'h0400, 16'h3C00, 7});
      vecs.push_back('{1'b1, 6'h01, 16'h0600, 16'hC200, 0});
      vecs.push_back('{1'b0, 6'h00, 16'h0001, 16'h1400, 16});
      vecs.push_back('{1'b0, 6'h00, 16'h0801, 16'h4000, 0});
      vecs.push_back('{1'b0, 6'h00, 16'h0803, 16'h4002, 0});
      vecs.push_back('{1'b0, 6'h00, 16'hFFFF, 16'h5400, 0});
      vecs.push_back('{1'b0, 6'h10, 16'h0400, 16'h7BFF, 0});
      vecs.push_back('{1'b1, 6'h10, 16'h0400, 16'hFBFF, 0});
      vecs.push_back('{1'b1, 6'h05, 16'h0000, 16'h8000, 5});
      vecs.push_back('{1'b0, 6'h10, 16'h0000, 16'h0000, 5});
`ifdef FLOAT_PACK_SUBNORM_EN
      vecs.push_back('{1'b0, 6'h31, 16'h0400, 16'h0200, 0});
`else
      vecs.push_back('{1'b0, 6'h31, 16'h0400, 16'h0000, 0});
`endif
      vecs.push_back('{1'b1, 6'h32, 16'h0400, 16'h8400, 0});
      vecs.push_back('{1'b0, 6'h30, 16'h0FFF, 16'h0400, 0});
      vecs.push_back('{1'b0, 6'h20, 16'h0400, 16'h0000, 0});

      foreach (vecs[i]) begin
         applyStimulus(vecs[i].sign, vecs[i].exp, vecs[i].mant, 0);
         checkOp($sformatf("vec%0d", i), vecs[i].result,
                 (vecs[i].cycle != 0) ? vecs[i].cycle : refCycles(vecs[i].exp, vecs[i].mant));
      end

      applyStimulus(1'b0, 6'h00, 16'h0001, 4);
      checkOp("start-in-norm", 16'h1400, 16);

      for (int i = 0; i < 40; i++) begin
         rs = 1'($urandom);
         re = 6'($urandom);
         rm = 16'($urandom) & 16'((32'd1 << $urandom_range(1, 16)) - 1);
         if ($urandom_range(0, 9) == 0) rm = 16'h0;
         applyStimulus(rs, re, rm, 0);
         checkOp($sformatf("rand%0d s=%0d e=%0h m=%0h", i, rs, re, rm), refModel(rs, re, rm), refCycles(re, rm));
      end

      @(negedge clk);
      bus.Sign  = 1'b0;
      bus.Exp   = 6'h00;
      bus.Mant  = 16'h0400;
      bus.Start = 1'b1;
      @(posedge clk);
      #1;
      bus.Start = 1'b0;
      reached   = 1'b0;
      for (int c = 1; c <= DONE_BUDGET; c++) begin
         @(negedge clk);
         if (bus.MemWrEn && bus.MemAddr == 8'(BASE_ADDR + 1)) begin
            reached = 1'b1;
            break;
         end
      end
      checkOutput("rst-wrhi reached", 32'(reached), 32'd1);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkIdleOutputs("rst-wrhi");
      doneSeen = 0;
      for (int c = 0; c < 12; c++) begin
         @(negedge clk);
         if (bus.Done || bus.MemWrEn) doneSeen++;
      end
      checkOutput("rst-wrhi no done", 32'(doneSeen), 32'd0);

      applyStimulus(1'b1, 6'h01, 16'h0600, 0);
      checkOp("after-reset", 16'hC200, refCycles(6'h01, 16'h0600));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
